// File: rtl/alu_pipe_if.sv
// Handshake bundle for alu_pipe: operand offer in, result/flags out.
// The producer/consumer side uses the master modport, the ALU uses slave.
interface alu_pipe_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned OPW   = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [OPW-1:0]   Opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] C;
    logic [4:0]       Flags;
    logic             err;

    modport master (
        output in_valid, A, B, Opcode, out_ready,
        input  in_ready, out_valid, C, Flags, err
    );

    modport slave (
        input  in_valid, A, B, Opcode, out_ready,
        output in_ready, out_valid, C, Flags, err
    );
endinterface

// File: rtl/alu_pipe.sv
// Valid/ready ALU: single-cycle arithmetic/logic/shift ops plus an iterative
// shift-add multiplier; results and {C,L,F,Z,N} flags are registered.
module alu_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned OPW   = 8
) (
    input logic       clk,
    input logic       rst_n,
    alu_pipe_if.slave bus
);
    localparam int unsigned    CntW   = $clog2(WIDTH + 1);
    localparam int unsigned    M      = WIDTH - 1;
    localparam logic [WIDTH-1:0] WidthW = WIDTH'(WIDTH);

    localparam logic [OPW-1:0] OpAdd  = OPW'(8'h05);
    localparam logic [OPW-1:0] OpAddu = OPW'(8'h06);
    localparam logic [OPW-1:0] OpAddc = OPW'(8'h07);
    localparam logic [OPW-1:0] OpSub  = OPW'(8'h09);
    localparam logic [OPW-1:0] OpCmp  = OPW'(8'h0B);
    localparam logic [OPW-1:0] OpAnd  = OPW'(8'h01);
    localparam logic [OPW-1:0] OpOr   = OPW'(8'h02);
    localparam logic [OPW-1:0] OpXor  = OPW'(8'h03);
    localparam logic [OPW-1:0] OpMov  = OPW'(8'h0D);
    localparam logic [OPW-1:0] OpLsh  = OPW'(8'h84);
    localparam logic [OPW-1:0] OpMul  = OPW'(8'h0E);

    typedef enum logic [0:0] {StIdle, StMul} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [4:0]       flags_q, flags_d;
    logic             err_q, err_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic             accept, is_mul, mul_done;
    logic [WIDTH-1:0] a, b, res, lsh, nb;
    logic [WIDTH:0]   add_w, addc_w, sub_w;
    logic [4:0]       flg;
    logic             ill, set_zn;

    assign a        = bus.A;
    assign b        = bus.B;
    assign is_mul   = (bus.Opcode == OpMul);
    assign mul_done = (state_q == StMul) && (cnt_q == CntW'(WIDTH));
    // Gated by rst_n so nothing is offered while the block is held in reset.
    assign bus.in_ready  = rst_n && (state_q == StIdle) && (!out_valid_q || bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.C         = c_q;
    assign bus.Flags     = flags_q;
    assign bus.err       = err_q;

    assign add_w  = {1'b0, a} + {1'b0, b};
    assign addc_w = add_w + {{WIDTH{1'b0}}, flags_q[4]};
    assign sub_w  = {1'b0, a} - {1'b0, b};

    // Signed shift amount: non-negative shifts left, negative shifts right.
    always_comb begin
        nb  = '0 - b;
        lsh = '0;
        if (!b[M]) begin
            if (b < WidthW) lsh = a << b;
        end else begin
            if (nb < WidthW) lsh = a >> nb;
        end
    end

    always_comb begin
        res    = '0;
        flg    = flags_q;
        ill    = 1'b0;
        set_zn = 1'b1;
        case (bus.Opcode)
            OpAdd: begin
                res    = add_w[M:0];
                flg[4] = add_w[WIDTH];
                flg[2] = (a[M] == b[M]) && (add_w[M] != a[M]);
            end
            OpAddu: begin
                res    = add_w[M:0];
                flg[4] = add_w[WIDTH];
            end
            OpAddc: begin
                res    = addc_w[M:0];
                flg[4] = addc_w[WIDTH];
                flg[2] = (a[M] == b[M]) && (addc_w[M] != a[M]);
            end
            OpSub: begin
                res    = sub_w[M:0];
                flg[4] = sub_w[WIDTH];
                flg[2] = (a[M] != b[M]) && (sub_w[M] != a[M]);
            end
            OpCmp: begin
                res    = a;
                set_zn = 1'b0;
                flg[3] = (a < b);
                flg[1] = (a == b);
                flg[0] = ($signed(a) < $signed(b));
            end
            OpAnd:   res = a & b;
            OpOr:    res = a | b;
            OpXor:   res = a ^ b;
            OpMov:   res = b;
            OpLsh:   res = lsh;
            OpMul:   set_zn = 1'b0;
            default: begin
                ill    = 1'b1;
                set_zn = 1'b0;
            end
        endcase
        if (set_zn) begin
            flg[1] = ~|res;
            flg[0] = res[M];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept && is_mul) state_d = StMul;
            StMul:   if (mul_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        c_d         = c_q;
        flags_d     = flags_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept && is_mul) begin
                    mcand_d  = a;
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                end else if (accept) begin
                    c_d         = res;
                    flags_d     = flg;
                    err_d       = ill;
                    out_valid_d = 1'b1;
                end
            end
            StMul: begin
                if (mul_done) begin
                    c_d         = acc_q;
                    flags_d[1]  = ~|acc_q;
                    flags_d[0]  = acc_q[M];
                    err_d       = 1'b0;
                    out_valid_d = 1'b1;
                end else begin
                    acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CntW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q         <= '0;
            flags_q     <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            c_q         <= c_d;
            flags_q     <= flags_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: a 16-bit instance for the main checks and an
// 8-bit instance for the narrower multiplier latency.
module tb_alu_pipe;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_pipe_if #(.WIDTH(16), .OPW(8)) b16 ();
    alu_pipe_if #(.WIDTH(8),  .OPW(8)) b8 ();

    alu_pipe #(.WIDTH(16), .OPW(8)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));
    alu_pipe #(.WIDTH(8),  .OPW(8)) dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Present one op on the 16-bit bus for exactly one edge.
    task automatic issue16(input logic [7:0] op, input logic [15:0] av, input logic [15:0] bv);
        b16.Opcode = op; b16.A = av; b16.B = bv; b16.in_valid = 1'b1;
        @(posedge clk); #1;
        b16.in_valid = 1'b0;
    endtask

    task automatic issue8(input logic [7:0] op, input logic [7:0] av, input logic [7:0] bv);
        b8.Opcode = op; b8.A = av; b8.B = bv; b8.in_valid = 1'b1;
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        n_checks++; if (b16.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", b16.out_valid); end
        n_checks++; if (b16.C !== 16'h0000) begin n_fail++; $display("FAIL rst_C: got %h expected 0000", b16.C); end
        n_checks++; if (b16.Flags !== 5'b00000) begin n_fail++; $display("FAIL rst_Flags: got %b expected 00000", b16.Flags); end
        n_checks++; if (b16.err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b expected 0", b16.err); end
        n_checks++; if (b16.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready_low: got %b expected 0", b16.in_ready); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (b16.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready_release: got %b expected 1", b16.in_ready); end
    endtask

    task automatic test_add_addc_cmp;
        b16.out_ready = 1'b1;
        issue16(8'h05, 16'hFFFF, 16'h0001);
        n_checks++; if (b16.out_valid !== 1'b1) begin n_fail++; $display("FAIL add_out_valid: got %b expected 1", b16.out_valid); end
        n_checks++; if (b16.C !== 16'h0000) begin n_fail++; $display("FAIL add_C: got %h expected 0000", b16.C); end
        n_checks++; if (b16.Flags !== 5'b10010) begin n_fail++; $display("FAIL add_Flags: got %b expected 10010", b16.Flags); end
        issue16(8'h07, 16'h0001, 16'h0001);
        n_checks++; if (b16.C !== 16'h0003) begin n_fail++; $display("FAIL addc_C: got %h expected 0003", b16.C); end
        n_checks++; if (b16.Flags !== 5'b00000) begin n_fail++; $display("FAIL addc_Flags: got %b expected 00000", b16.Flags); end
        issue16(8'h0B, 16'h8000, 16'h0001);
        n_checks++; if (b16.C !== 16'h8000) begin n_fail++; $display("FAIL cmp_C: got %h expected 8000", b16.C); end
        n_checks++; if (b16.Flags !== 5'b00001) begin n_fail++; $display("FAIL cmp_Flags: got %b expected 00001", b16.Flags); end
        n_checks++; if (b16.err !== 1'b0) begin n_fail++; $display("FAIL cmp_err: got %b expected 0", b16.err); end
    endtask

    task automatic test_mul;
        issue16(8'h0E, 16'h0003, 16'h0005);
        // Producer immediately offers an ADD and holds it through the multiply.
        b16.Opcode = 8'h05; b16.A = 16'h0010; b16.B = 16'h0020; b16.in_valid = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            n_checks++; if (b16.in_ready !== 1'b0) begin n_fail++; $display("FAIL mul_in_ready[%0d]: got %b expected 0", k, b16.in_ready); end
            @(posedge clk); #1;
            n_checks++; if (b16.out_valid !== 1'b0) begin n_fail++; $display("FAIL mul_early_valid[%0d]: got %b expected 0", k, b16.out_valid); end
        end
        n_checks++; if (b16.in_ready !== 1'b0) begin n_fail++; $display("FAIL mul_in_ready_last: got %b expected 0", b16.in_ready); end
        @(posedge clk); #1;
        n_checks++; if (b16.out_valid !== 1'b1) begin n_fail++; $display("FAIL mul_valid17: got %b expected 1", b16.out_valid); end
        n_checks++; if (b16.C !== 16'h000F) begin n_fail++; $display("FAIL mul_C: got %h expected 000f", b16.C); end
        n_checks++; if (b16.Flags !== 5'b00000) begin n_fail++; $display("FAIL mul_Flags: got %b expected 00000", b16.Flags); end
        n_checks++; if (b16.in_ready !== 1'b1) begin n_fail++; $display("FAIL mul_ready_after: got %b expected 1", b16.in_ready); end
        @(posedge clk); #1;
        b16.in_valid = 1'b0;
        n_checks++; if (b16.C !== 16'h0030) begin n_fail++; $display("FAIL held_add_C: got %h expected 0030", b16.C); end
    endtask

    task automatic test_sub_stall;
        issue16(8'h09, 16'h0005, 16'h0007);
        b16.out_ready = 1'b0;
        b16.Opcode = 8'h05; b16.A = 16'h0001; b16.B = 16'h0001; b16.in_valid = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (b16.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready[%0d]: got %b expected 0", k, b16.in_ready); end
            n_checks++; if (b16.C !== 16'hFFFE) begin n_fail++; $display("FAIL stall_C[%0d]: got %h expected fffe", k, b16.C); end
            n_checks++; if (b16.Flags !== 5'b10001) begin n_fail++; $display("FAIL stall_Flags[%0d]: got %b expected 10001", k, b16.Flags); end
            n_checks++; if (b16.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b expected 1", k, b16.out_valid); end
            @(posedge clk); #1;
        end
        b16.out_ready = 1'b1;
        #1;
        n_checks++; if (b16.in_ready !== 1'b1) begin n_fail++; $display("FAIL unstall_ready: got %b expected 1", b16.in_ready); end
        @(posedge clk); #1;
        b16.in_valid = 1'b0;
        n_checks++; if (b16.C !== 16'h0002) begin n_fail++; $display("FAIL unstall_C: got %h expected 0002", b16.C); end
        n_checks++; if (b16.out_valid !== 1'b1) begin n_fail++; $display("FAIL unstall_valid: got %b expected 1", b16.out_valid); end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  ops [4];
        logic [15:0] as  [4];
        logic [15:0] bs  [4];
        logic [15:0] cs  [4];
        logic [4:0]  fs  [4];
        ops = '{8'h01, 8'h02, 8'h03, 8'h0D};
        as  = '{16'hF0F0, 16'h0F0F, 16'hAAAA, 16'h5555};
        bs  = '{16'hFF00, 16'h00F0, 16'hAAAA, 16'h1234};
        cs  = '{16'hF000, 16'h0FFF, 16'h0000, 16'h1234};
        fs  = '{5'b00001, 5'b00000, 5'b00010, 5'b00000};
        b16.in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            b16.Opcode = ops[k]; b16.A = as[k]; b16.B = bs[k];
            n_checks++; if (b16.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b expected 1", k, b16.in_ready); end
            @(posedge clk); #1;
            n_checks++; if (b16.C !== cs[k]) begin n_fail++; $display("FAIL b2b_C[%0d]: got %h expected %h", k, b16.C, cs[k]); end
            n_checks++; if (b16.Flags !== fs[k]) begin n_fail++; $display("FAIL b2b_Flags[%0d]: got %b expected %b", k, b16.Flags, fs[k]); end
        end
        b16.in_valid = 1'b0;
    endtask

    task automatic test_lsh_illegal;
        issue16(8'h05, 16'hFFFF, 16'h0001);
        issue16(8'h84, 16'h00F0, 16'hFFFC);
        n_checks++; if (b16.C !== 16'h000F) begin n_fail++; $display("FAIL lsh_right_C: got %h expected 000f", b16.C); end
        n_checks++; if (b16.Flags !== 5'b10000) begin n_fail++; $display("FAIL lsh_right_Flags: got %b expected 10000", b16.Flags); end
        issue16(8'h84, 16'h00F0, 16'h0010);
        n_checks++; if (b16.C !== 16'h0000) begin n_fail++; $display("FAIL lsh_16_C: got %h expected 0000", b16.C); end
        n_checks++; if (b16.Flags !== 5'b10010) begin n_fail++; $display("FAIL lsh_16_Flags: got %b expected 10010", b16.Flags); end
        issue16(8'h84, 16'h0001, 16'h000F);
        n_checks++; if (b16.C !== 16'h8000) begin n_fail++; $display("FAIL lsh_15_C: got %h expected 8000", b16.C); end
        issue16(8'h84, 16'h8000, 16'hFFF0);
        n_checks++; if (b16.C !== 16'h0000) begin n_fail++; $display("FAIL lsh_neg16_C: got %h expected 0000", b16.C); end
        n_checks++; if (b16.Flags !== 5'b10010) begin n_fail++; $display("FAIL lsh_neg16_Flags: got %b expected 10010", b16.Flags); end
        issue16(8'hFF, 16'h1234, 16'h0001);
        n_checks++; if (b16.C !== 16'h0000) begin n_fail++; $display("FAIL illegal_C: got %h expected 0000", b16.C); end
        n_checks++; if (b16.err !== 1'b1) begin n_fail++; $display("FAIL illegal_err: got %b expected 1", b16.err); end
        n_checks++; if (b16.Flags !== 5'b10010) begin n_fail++; $display("FAIL illegal_Flags: got %b expected 10010", b16.Flags); end
        n_checks++; if (b16.out_valid !== 1'b1) begin n_fail++; $display("FAIL illegal_valid: got %b expected 1", b16.out_valid); end
        issue16(8'h05, 16'h7FFF, 16'h0001);
        n_checks++; if (b16.Flags !== 5'b00101) begin n_fail++; $display("FAIL add_ovf_Flags: got %b expected 00101", b16.Flags); end
        n_checks++; if (b16.err !== 1'b0) begin n_fail++; $display("FAIL legal_err: got %b expected 0", b16.err); end
        issue16(8'h06, 16'h7FFF, 16'h0001);
        n_checks++; if (b16.Flags !== 5'b00101) begin n_fail++; $display("FAIL addu_Flags: got %b expected 00101", b16.Flags); end
        issue16(8'h09, 16'h8000, 16'h0001);
        n_checks++; if (b16.C !== 16'h7FFF) begin n_fail++; $display("FAIL sub_ovf_C: got %h expected 7fff", b16.C); end
        n_checks++; if (b16.Flags !== 5'b00100) begin n_fail++; $display("FAIL sub_ovf_Flags: got %b expected 00100", b16.Flags); end
    endtask

    task automatic test_reset_mid_mul;
        logic seen;
        issue16(8'h0E, 16'h0003, 16'h0005);
        for (int k = 0; k < 4; k++) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        n_checks++; if (b16.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", b16.out_valid); end
        n_checks++; if (b16.Flags !== 5'b00000) begin n_fail++; $display("FAIL midrst_Flags: got %b expected 00000", b16.Flags); end
        n_checks++; if (b16.in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b expected 0", b16.in_ready); end
        @(posedge clk); @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            seen = seen | b16.out_valid;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL aborted_mul_result: got %b expected 0", seen); end
        issue16(8'h05, 16'h0002, 16'h0003);
        n_checks++; if (b16.C !== 16'h0005) begin n_fail++; $display("FAIL post_rst_add_C: got %h expected 0005", b16.C); end
        n_checks++; if (b16.out_valid !== 1'b1) begin n_fail++; $display("FAIL post_rst_add_valid: got %b expected 1", b16.out_valid); end
    endtask

    task automatic test_mul8;
        b8.out_ready = 1'b1;
        issue8(8'h0E, 8'h0D, 8'h0B);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            n_checks++; if (b8.out_valid !== 1'b0) begin n_fail++; $display("FAIL mul8_early_valid[%0d]: got %b expected 0", k, b8.out_valid); end
        end
        @(posedge clk); #1;
        n_checks++; if (b8.out_valid !== 1'b1) begin n_fail++; $display("FAIL mul8_valid9: got %b expected 1", b8.out_valid); end
        n_checks++; if (b8.C !== 8'h8F) begin n_fail++; $display("FAIL mul8_C: got %h expected 8f", b8.C); end
        n_checks++; if (b8.Flags !== 5'b00001) begin n_fail++; $display("FAIL mul8_Flags: got %b expected 00001", b8.Flags); end
        issue8(8'h0E, 8'h10, 8'h10);
        for (int k = 1; k <= 9; k++) begin @(posedge clk); #1; end
        n_checks++; if (b8.C !== 8'h00) begin n_fail++; $display("FAIL mul8_trunc_C: got %h expected 00", b8.C); end
        n_checks++; if (b8.Flags !== 5'b00010) begin n_fail++; $display("FAIL mul8_trunc_Flags: got %b expected 00010", b8.Flags); end
    endtask

    initial begin
        b16.in_valid = 1'b0; b16.A = '0; b16.B = '0; b16.Opcode = '0; b16.out_ready = 1'b0;
        b8.in_valid  = 1'b0; b8.A  = '0; b8.B  = '0; b8.Opcode  = '0; b8.out_ready  = 1'b0;
        test_reset;
        test_add_addc_cmp;
        test_mul;
        test_sub_stall;
        test_back_to_back;
        test_lsh_illegal;
        test_reset_mid_mul;
        test_mul8;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits (legal range 4..32).
REQ-002 Parameter OPW, default 8, opcode width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  operand/opcode offer from producer.
REQ-006 in_ready  output  1  block can accept an operation this cycle.
REQ-007 A  input  WIDTH  first operand.
REQ-008 B  input  WIDTH  second operand / shift amount.
REQ-009 Opcode  input  OPW  operation select.
REQ-010 out_valid  output  1  C/Flags/err hold a completed result.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 C  output  WIDTH  registered result.
REQ-013 Flags  output  5  registered flags {C,L,F,Z,N} = bits [4:0].
REQ-014 err  output  1  completed operation had an illegal opcode.

Function
REQ-015 Transfer in occurs when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-016 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready), combinationally.
REQ-017 Operands and opcode SHALL be captured on in-transfer; later changes on A/B/Opcode have no effect on that operation.
REQ-018 FSM states: IDLE, MUL; IDLE->MUL on accepted MUL, MUL->IDLE after WIDTH iteration cycles; all other ops stay in IDLE.
REQ-019 Single-cycle ops: C, Flags, err, out_valid=1 updated at the edge that performs the in-transfer (latency 1).
REQ-020 MUL: shift-add iterative, one bit of B per cycle; C = low WIDTH bits of unsigned A*B; out_valid rises exactly WIDTH+1 edges after the accepting edge.
REQ-021 out_valid SHALL clear on out-transfer unless a new result is loaded the same edge (back-to-back at full rate for single-cycle ops).
REQ-022 C/Flags/err SHALL hold stable while out_valid && !out_ready.
REQ-023 Opcodes (hex): 05 ADD, 06 ADDU, 07 ADDC, 09 SUB, 0B CMP, 01 AND, 02 OR, 03 XOR, 0D MOV (C=B), 84 LSH, 0E MUL; all others illegal.
REQ-024 ADD/ADDU/ADDC/SUB: C = A+B, A+B, A+B+Flags[4], A-B, modulo 2^WIDTH.
REQ-025 CMP: C = A unchanged output value A; only flags computed from A-B.
REQ-026 LSH: B interpreted signed; B>=0 shift A left by B, B<0 logical right by -B; |B|>=WIDTH yields 0.
REQ-027 Flag C (bit4): carry-out of ADD/ADDU/ADDC, borrow of SUB; unchanged otherwise.
REQ-028 Flag L (bit3): CMP only, 1 iff A<B unsigned.
REQ-029 Flag F (bit2): signed overflow of ADD/ADDC/SUB; unchanged otherwise.
REQ-030 Flag Z (bit1): 1 iff result (CMP: A==B) is zero; updated by every legal op.
REQ-031 Flag N (bit0): CMP: 1 iff A<B signed; other legal ops: result MSB.
REQ-032 Flags not listed as updated for an op SHALL retain previous value.
REQ-033 Illegal opcode: completes in 1 cycle, C=0, err=1, Flags unchanged; err=0 for all legal ops.
REQ-034 ADDC uses Flags[4] as it stands at the accepting edge (result of the previously completed op).
REQ-035 No in-transfer while in MUL; in_valid held by producer is not lost.

Reset
REQ-036 rst_n low SHALL immediately force state=IDLE, out_valid=0, C=0, Flags=5'b00000, err=0, MUL accumulator/counter cleared.
REQ-037 Reset during MUL SHALL abort it; no result is ever produced for the aborted operation.
REQ-038 in_ready SHALL be 0 while rst_n low and 1 on the first edge after release (out_valid=0, IDLE).

Verification
REQ-039 WIDTH=16: ADD A=0xFFFF B=0x0001, out_ready=1 -> next edge C=0x0000, Flags[4]=1, Flags[1]=1, F=0, out_valid=1.
REQ-040 Then ADDC A=0x0001 B=0x0001 -> C=0x0003, Flags[4]=0; CMP A=0x8000 B=0x0001 -> L=0, N=1, Z=0, C output 0x8000.
REQ-041 MUL A=0x0003 B=0x0005 -> in_ready=0 for 16 cycles, out_valid rises 17 edges after accept, C=0x000F, Z=0, N=0.
REQ-042 out_ready=0 after SUB A=5 B=7 -> C=0xFFFE held, in_ready=0 until out_ready=1; F=0, Flags[4]=1.
REQ-043 LSH A=0x00F0 B=0xFFFC (-4) -> C=0x000F; B=16 -> C=0; Opcode=0xFF -> C=0, err=1, Flags unchanged.
REQ-044 rst_n low mid-MUL (cycle 5) -> out_valid=0, Flags=0 immediately; after release ADD 2+3 -> C=5 in 1 cycle; repeat MUL with WIDTH=8 -> latency 9 edges.
